// File: rtl/sent_tx_frame_gen.sv
// SENT frame transmitter: sync, status, NIBBLES data nibbles, CRC4 and optional constant-length pause.
// Latency: data_pulse goes low one clk after accept; frame_ready only in IDLE or on a frame's last clk.
module sent_tx_frame_gen #(
    parameter int NIBBLES     = 6,
    parameter int CLK_DIV     = 3,
    parameter int LOW_TICKS   = 5,
    parameter int FRAME_TICKS = 300
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pause_en,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [3:0]           status_nibble,
    input  logic [4*NIBBLES-1:0] frame_data,
    output logic                 data_pulse,
    output logic                 busy,
    output logic                 frame_done,
    output logic [3:0]           crc_out
);
    localparam int LONGEST   = 56 + 27 * (NIBBLES + 3);
    localparam int MAX_TICKS = (FRAME_TICKS > LONGEST) ? FRAME_TICKS : LONGEST;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NW        = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int DATA_W    = 4 * NIBBLES;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_STATUS = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CRC    = 3'd4;
    localparam logic [2:0] S_PAUSE  = 3'd5;

    logic [2:0]        state, state_nxt;
    logic [DW-1:0]     div_cnt;
    logic [TW-1:0]     tick_cnt;
    logic [TW-1:0]     frame_tick;
    logic [NW-1:0]     nib_idx;
    logic [DATA_W-1:0] data_sr;
    logic [3:0]        status_q;
    logic              pause_q;
    logic [3:0]        cur_nib;
    logic [3:0]        crc_acc;
    logic [3:0]        crc_calc;
    logic              tick_end;
    logic              seg_last_tick;
    logic              seg_end;
    logic              frame_last;
    logic              accept;

    // Multiply-by-x^4 mod (x^4+x^3+x^2+1) is linear, so XOR the images of each bit.
    function automatic logic [3:0] crc_tab(input logic [3:0] c);
        crc_tab = ({4{c[0]}} & 4'hD) ^ ({4{c[1]}} & 4'h7) ^
                  ({4{c[2]}} & 4'hE) ^ ({4{c[3]}} & 4'h1);
    endfunction

    always_comb begin
        crc_acc = 4'h5;
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            crc_acc = crc_tab(crc_acc) ^ frame_data[4*i +: 4];
        end
        crc_calc = crc_tab(crc_acc);
    end

    always_comb begin
        cur_nib = 4'h0;
        case (state)
            S_STATUS: cur_nib = status_q;
            S_DATA:   cur_nib = data_sr[DATA_W-1 -: 4];
            S_CRC:    cur_nib = crc_out;
            default:  cur_nib = 4'h0;
        endcase
    end

    assign tick_end = (div_cnt == DW'(CLK_DIV - 1));

    // Pause ends once the whole frame reaches FRAME_TICKS, but never before its 12th tick.
    always_comb begin
        seg_last_tick = 1'b0;
        case (state)
            S_SYNC:                 seg_last_tick = (tick_cnt == TW'(55));
            S_STATUS, S_DATA, S_CRC: seg_last_tick = (tick_cnt == TW'(11) + TW'(cur_nib));
            S_PAUSE:                seg_last_tick = (tick_cnt >= TW'(11)) &&
                                                    (frame_tick >= TW'(FRAME_TICKS - 1));
            default:                seg_last_tick = 1'b0;
        endcase
    end

    assign seg_end     = tick_end && seg_last_tick;
    assign frame_last  = seg_end && ((state == S_CRC && !pause_q) || state == S_PAUSE);
    assign frame_ready = enable && (state == S_IDLE || frame_last);
    assign accept      = frame_valid && frame_ready;
    assign frame_done  = frame_last;
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC:   state_nxt = S_STATUS;
            S_STATUS: state_nxt = S_DATA;
            S_DATA:   state_nxt = (nib_idx == NW'(NIBBLES - 1)) ? S_CRC : S_DATA;
            S_CRC:    state_nxt = pause_q ? S_PAUSE : S_IDLE;
            S_PAUSE:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            frame_tick <= '0;
            nib_idx    <= '0;
            data_sr    <= '0;
            status_q   <= '0;
            pause_q    <= 1'b0;
            crc_out    <= '0;
            data_pulse <= 1'b1;
        end else begin
            data_pulse <= (state == S_IDLE) ? 1'b1 : (tick_cnt >= TW'(LOW_TICKS));
            if (accept) begin
                state      <= S_SYNC;
                div_cnt    <= '0;
                tick_cnt   <= '0;
                frame_tick <= '0;
                nib_idx    <= '0;
                data_sr    <= frame_data;
                status_q   <= status_nibble;
                pause_q    <= pause_en;
                crc_out    <= crc_calc;
            end else if (state != S_IDLE) begin
                div_cnt <= tick_end ? '0 : div_cnt + 1'b1;
                if (tick_end) begin
                    frame_tick <= frame_tick + 1'b1;
                    tick_cnt   <= seg_end ? '0 : tick_cnt + 1'b1;
                end
                if (seg_end) begin
                    state <= state_nxt;
                    if (state == S_DATA) begin
                        nib_idx <= nib_idx + 1'b1;
                        data_sr <= data_sr << 4;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Bench for sent_tx_frame_gen: two instances (6-nibble/300-tick and 1-nibble/100-tick frames),
// stimulus pushes hand-computed segment lengths and CRC/frame length; a negedge monitor compares.
module tb_sent_tx_frame_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en [2];
    logic       pe [2];
    logic       fv [2];
    logic       fr [2];
    logic       dp [2];
    logic       bz [2];
    logic       fdn [2];
    logic [3:0] st [2];
    logic [3:0] crc [2];
    logic [23:0] fd_a;
    logic [3:0]  fd_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int crc;
        int clks;
    } exp_t;
    exp_t exp_frame[$];
    int   exp_seg[$];

    int seg_start [2];
    int acc_cyc [2];
    int nxt_fall [2];
    bit seg_open [2];
    bit inframe [2];
    bit prev_dp [2];

    sent_tx_frame_gen #(.NIBBLES(6), .CLK_DIV(3), .LOW_TICKS(5), .FRAME_TICKS(300)) dut_a (
        .clk(clk), .reset(rst_n), .enable(en[0]), .pause_en(pe[0]),
        .frame_valid(fv[0]), .frame_ready(fr[0]), .status_nibble(st[0]),
        .frame_data(fd_a), .data_pulse(dp[0]), .busy(bz[0]),
        .frame_done(fdn[0]), .crc_out(crc[0])
    );

    sent_tx_frame_gen #(.NIBBLES(1), .CLK_DIV(3), .LOW_TICKS(5), .FRAME_TICKS(100)) dut_b (
        .clk(clk), .reset(rst_n), .enable(en[1]), .pause_en(pe[1]),
        .frame_valid(fv[1]), .frame_ready(fr[1]), .status_nibble(st[1]),
        .frame_data(fd_b), .data_pulse(dp[1]), .busy(bz[1]),
        .frame_done(fdn[1]), .crc_out(crc[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_seg(input int ticks);
        exp_seg.push_back(ticks * 3);
    endtask

    task automatic push_frame(input int c, input int clks);
        exp_t e;
        e.crc  = c;
        e.clks = clks;
        exp_frame.push_back(e);
    endtask

    // Inputs change 1ns after posedge so the negedge monitor sees what the next edge samples.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [23:0] data, input logic [3:0] s,
                        input logic p, input bit hold);
        int n;
        if (d == 0) fd_a = data;
        else        fd_b = data[3:0];
        st[d] = s;
        pe[d] = p;
        fv[d] = 1'b1;
        n = 0;
        while (!fr[d] && n < 3000) begin
            tick();
            n++;
        end
        if (!fr[d]) begin
            fail_now("accept_timeout");
            fv[d] = 1'b0;
        end else begin
            tick();
            if (!hold) fv[d] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (bz[d] && n < 5000) begin
            tick();
            n++;
        end
        if (bz[d]) fail_now("idle_timeout");
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_en) begin
                if (inframe[d]) chk("busy_in_frame", int'(bz[d]), 1);
                if (fdn[d]) begin
                    if (exp_frame.size() == 0) begin
                        fail_now("frame_unexpected");
                    end else begin
                        exp_t e;
                        e = exp_frame.pop_front();
                        chk("crc_out", int'(crc[d]), e.crc);
                        chk("frame_clks", cyc - acc_cyc[d], e.clks);
                    end
                    if (exp_seg.size() == 0) fail_now("seg_unexpected");
                    else chk("last_seg_clks", cyc + 2 - seg_start[d], exp_seg.pop_front());
                    inframe[d]  = 1'b0;
                    seg_open[d] = 1'b0;
                end
                if (fv[d] && fr[d]) begin
                    if (bz[d]) chk("accept_on_done", int'(fdn[d]), 1);
                    acc_cyc[d]  = cyc;
                    inframe[d]  = 1'b1;
                    nxt_fall[d] = cyc + 2;
                end
                if (prev_dp[d] && !dp[d]) begin
                    if (seg_open[d]) begin
                        if (exp_seg.size() == 0) fail_now("seg_unexpected");
                        else chk("seg_clks", cyc - seg_start[d], exp_seg.pop_front());
                    end
                    if (nxt_fall[d] >= 0) begin
                        chk("sync_start", cyc, nxt_fall[d]);
                        nxt_fall[d] = -1;
                    end
                    seg_start[d] = cyc;
                    seg_open[d]  = 1'b1;
                end
                if (!prev_dp[d] && dp[d] && seg_open[d])
                    chk("low_clks", cyc - seg_start[d], 15);
            end
            prev_dp[d] = dp[d];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; pe[i] = 1'b0; fv[i] = 1'b0; st[i] = 4'h0;
            seg_start[i] = 0; acc_cyc[i] = 0; nxt_fall[i] = -1;
            seg_open[i] = 1'b0; inframe[i] = 1'b0; prev_dp[i] = 1'b1;
        end
        fd_a = '0;
        fd_b = '0;

        repeat (3) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_data_pulse", int'(dp[d]), 1);
            chk("rst_busy", int'(bz[d]), 0);
            chk("rst_frame_done", int'(fdn[d]), 0);
            chk("rst_crc_out", int'(crc[d]), 0);
        end
        tick();
        rst_n = 1'b1;
        en[0] = 1'b1;
        en[1] = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_ready_a", int'(fr[0]), 1);
        chk("idle_ready_b", int'(fr[1]), 1);
        chk("idle_pulse_a", int'(dp[0]), 1);

        // Abort a frame during the SYNC low phase with an async reset.
        tick();
        send(0, 24'h123456, 4'h3, 1'b0, 1'b0);
        repeat (5) tick();
        @(negedge clk);
        chk("sync_low_before_rst", int'(dp[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_sync_pulse", int'(dp[0]), 1);
        chk("rst_mid_sync_busy", int'(bz[0]), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;

        // All-zero frame, no pause: CRC 5, 56+7*12+17 = 157 ticks.
        push_seg(56);
        repeat (7) push_seg(12);
        push_seg(17);
        push_frame(5, 471);
        send(0, 24'h000000, 4'h0, 1'b0, 1'b0);
        wait_idle(0);

        // Same frame padded to 300 ticks: pause 143.
        push_seg(56);
        repeat (7) push_seg(12);
        push_seg(17);
        push_seg(143);
        push_frame(5, 900);
        send(0, 24'h000000, 4'h0, 1'b1, 1'b0);
        wait_idle(0);

        // Back-to-back: 0x123456/status 3 (CRC 2) then 0xFEDCBA/status A with pause (CRC E).
        push_seg(56); push_seg(15);
        push_seg(13); push_seg(14); push_seg(15); push_seg(16); push_seg(17); push_seg(18);
        push_seg(14);
        push_frame(2, 534);
        push_seg(56); push_seg(22);
        push_seg(27); push_seg(26); push_seg(25); push_seg(24); push_seg(23); push_seg(22);
        push_seg(26); push_seg(49);
        push_frame(14, 900);
        send(0, 24'h123456, 4'h3, 1'b0, 1'b1);
        send(0, 24'hFEDCBA, 4'hA, 1'b1, 1'b0);
        wait_idle(0);

        // Enable dropped mid-DATA with frame_valid still high: frame completes, nothing new.
        push_seg(56); push_seg(12);
        repeat (5) push_seg(12);
        push_seg(13); push_seg(20);
        push_frame(8, 483);
        send(0, 24'h000001, 4'h0, 1'b0, 1'b1);
        repeat (260) tick();
        en[0] = 1'b0;
        wait_idle(0);
        @(negedge clk);
        chk("en_off_ready", int'(fr[0]), 0);
        chk("en_off_pulse", int'(dp[0]), 1);
        chk("en_off_busy", int'(bz[0]), 0);
        repeat (20) tick();
        @(negedge clk);
        chk("en_off_ready_later", int'(fr[0]), 0);
        chk("en_off_busy_later", int'(bz[0]), 0);
        tick();
        fv[0] = 1'b0;
        en[0] = 1'b1;

        // One nibble 0x0: CRC A, 56+12+12+22 = 102 ticks.
        push_seg(56); push_seg(12); push_seg(12); push_seg(22);
        push_frame(10, 306);
        send(1, 24'h0, 4'h0, 1'b0, 1'b0);
        wait_idle(1);

        // One nibble 0xF, status F: CRC F, 137 ticks exceeds 100 so pause floors to 12.
        push_seg(56); push_seg(27); push_seg(27); push_seg(27); push_seg(12);
        push_frame(15, 447);
        send(1, 24'hF, 4'hF, 1'b1, 1'b0);
        wait_idle(1);

        repeat (5) tick();
        chk("seg_queue_drained", exp_seg.size(), 0);
        chk("frame_queue_drained", exp_frame.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
